// File: rtl/systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : systolic_seq_ctrl
// Description : Sequencer for an N x N output-stationary systolic MAC array.
//               A start command latches the inner length K and reads K
//               operand vectors (addresses 0..K-1). It then steps
//               (valid, first) tokens down a delay line so that each
//               anti-diagonal d = r+c gets its accumulator enable/sync-load
//               strobes at the moment its operands arrive. o_done pulses
//               once every PE holds its final result.
// Ports       : i_clk, i_rst_n (async, active-low)
//               i_start, i_k      - command strobe and inner length K
//               o_busy, o_done    - run status / completion pulse
//               o_err             - pulse when a start with K == 0 is rejected
//               o_rd_en, o_rd_addr- operand memory read strobe / index
//               o_en, o_sync      - per-anti-diagonal enable / sync-load
//               o_cycles          - busy-cycle count of the last completed run
//                                   (only with SYSTOLIC_SEQ_CTRL_PERF_EN)
// Options     : SYSTOLIC_SEQ_CTRL_PERF_EN - adds the o_cycles counter port
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_seq_ctrl #(
  parameter int N   = 4,
  parameter int K_W = 16,
  parameter int L   = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [K_W-1:0]   i_k,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic             o_rd_en,
  output logic [K_W-1:0]   o_rd_addr,
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
  output logic [31:0]      o_cycles,
`endif
  output logic [2*N-2:0]   o_en,
  output logic [2*N-2:0]   o_sync
);

  localparam int D   = 2*N - 1;      // anti-diagonal count
  localparam int LEN = L + 2*N - 2;  // token delay-line length

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_FEED  = 2'd1;
  localparam logic [1:0] c_ST_DRAIN = 2'd2;
  localparam logic [1:0] c_ST_DONE  = 2'd3;

  logic [1:0]     r_state;
  logic [K_W-1:0] r_k;
  logic [K_W-1:0] r_addr;
  logic [LEN-1:0] r_vld;
  logic [LEN-1:0] r_fst;
  logic           r_err;

  logic w_feed;
  logic w_first;
  logic w_last_rd;
  logic w_drained;

  assign w_feed    = (r_state == c_ST_FEED);
  assign w_first   = w_feed && (r_addr == '0);
  assign w_last_rd = (r_addr == (r_k - K_W'(1)));
  // Shifting the last tap out leaves zero exactly when the final token is
  // sitting in the last tap, i.e. this is the last cycle any o_en is high.
  assign w_drained = ((r_vld << 1) == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= c_ST_IDLE;
      r_k     <= '0;
      r_addr  <= '0;
      r_vld   <= '0;
      r_fst   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      // One token per FEED cycle enters tap 0; tap j is seen j+1 cycles later.
      r_vld <= (r_vld << 1) | LEN'(w_feed);
      r_fst <= (r_fst << 1) | LEN'(w_first);
      case (r_state)
        c_ST_IDLE: begin
          if (i_start) begin
            if (i_k == '0) begin
              r_err <= 1'b1;
            end else begin
              r_k     <= i_k;
              r_addr  <= '0;
              r_state <= c_ST_FEED;
            end
          end
        end
        c_ST_FEED: begin
          if (w_last_rd) begin
            r_state <= c_ST_DRAIN;
          end else begin
            r_addr <= r_addr + K_W'(1);
          end
        end
        c_ST_DRAIN: begin
          if (w_drained) begin
            r_state <= c_ST_DONE;
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
  logic [31:0] r_run;
  logic [31:0] r_cycles;

  // r_run counts busy cycles already completed. On the DRAIN->DONE edge it
  // misses the current DRAIN cycle and the upcoming DONE cycle, hence +2.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run    <= '0;
      r_cycles <= '0;
    end else begin
      if (r_state == c_ST_IDLE) begin
        r_run <= '0;
      end else if (r_state != c_ST_DONE) begin
        r_run <= r_run + 32'd1;
      end
      if (r_state == c_ST_DRAIN && w_drained) begin
        r_cycles <= r_run + 32'd2;
      end
    end
  end

  assign o_cycles = r_cycles;
`endif

  assign o_busy    = (r_state != c_ST_IDLE);
  assign o_done    = (r_state == c_ST_DONE);
  assign o_err     = r_err;
  assign o_rd_en   = w_feed;
  assign o_rd_addr = r_addr;

  // Diagonal d sees its operands d cycles after diagonal 0, which itself
  // lags the read strobe by L cycles.
  for (genvar d = 0; d < D; d++) begin : g_diag
    assign o_en[d]   = r_vld[L+d-1];
    assign o_sync[d] = r_fst[L+d-1];
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_seq_ctrl
// Description : Self-checking bench for systolic_seq_ctrl (N=4, L=2).
//               Hand-written table for a K=3 run plus timing-formula checks
//               for zero length, start-while-busy, K=1 and mid-run reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_seq_ctrl;

  localparam int N   = 4;
  localparam int K_W = 16;
  localparam int L   = 2;
  localparam int D   = 2*N - 1;
  localparam int OW  = 4 + K_W + 2*D;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [K_W-1:0] k = '0;
  logic           busy, done, err, rd_en;
  logic [K_W-1:0] rd_addr;
  logic [D-1:0]   en, sync;
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
  logic [31:0]    cycles;
  logic [31:0]    cyc_log [0:31];
`endif

  int checks   = 0;
  int failures = 0;
  logic [OW-1:0] obs_log [0:31];

  systolic_seq_ctrl #(.N(N), .K_W(K_W), .L(L)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_k       (k),
    .o_busy    (busy),
    .o_done    (done),
    .o_err     (err),
    .o_rd_en   (rd_en),
    .o_rd_addr (rd_addr),
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
    .o_cycles  (cycles),
`endif
    .o_en      (en),
    .o_sync    (sync)
  );

  always #5 clk = ~clk;

  // Observed outputs; the address only matters while the read strobe is up.
  function automatic logic [OW-1:0] pack_obs();
    return {busy, done, err, rd_en, (rd_en ? rd_addr : {K_W{1'b0}}), en, sync};
  endfunction

  // Expected outputs at cycle c for a run whose start is accepted at cycle s0.
  function automatic logic [OW-1:0] model_run(int c, int s0, int kk);
    logic b, dn, rd;
    logic [K_W-1:0] a;
    logic [D-1:0] e, sy;
    int s;
    if (s0 < 0) return '0;
    s  = s0 + 1;
    b  = (c >= s) && (c <= s + kk + L + 2*N - 2);
    dn = (c == s + kk + L + 2*N - 2);
    rd = (c >= s) && (c < s + kk);
    a  = rd ? K_W'(c - s) : '0;
    e  = '0;
    sy = '0;
    for (int d = 0; d < D; d++) begin
      e[d]  = (c >= s + L + d) && (c <= s + L + d + kk - 1);
      sy[d] = (c == s + L + d);
    end
    return {b, dn, 1'b0, rd, a, e, sy};
  endfunction

  task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Start run A (K=ka) at cycle 0, extra starts with K=7 at ign_a/ign_b,
  // and run B (K=kb) at cycle sb; every cycle 1..ncyc is checked.
  task automatic run_seq(input int ka, input int ign_a, input int ign_b,
                         input int sb, input int kb, input int ncyc, input string tag);
    logic [OW-1:0] o;
    for (int c = 0; c <= ncyc; c++) begin
      @(negedge clk);
      o = pack_obs();
      obs_log[c] = o;
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
      cyc_log[c] = cycles;
`endif
      if (c > 0)
        check($sformatf("%s_c%0d", tag, c), o, model_run(c, 0, ka) | model_run(c, sb, kb));
      start = 1'b0;
      if (c == 0) begin
        start = 1'b1; k = K_W'(ka);
      end else if (c == ign_a || c == ign_b) begin
        start = 1'b1; k = K_W'(7);
      end else if (c == sb) begin
        start = 1'b1; k = K_W'(kb);
      end
    end
    start = 1'b0;
  endtask

  typedef struct {
    int             cyc;
    logic           busy;
    logic           rd;
    logic [K_W-1:0] addr;
    logic [D-1:0]   en;
    logic [D-1:0]   sync;
    logic           done;
  } vec_t;

  vec_t tbl [14];

  initial begin
    // Hand-derived trace of a K=3 run accepted at cycle 0.
    tbl[0]  = '{0,  1'b0, 1'b0, 16'd0, 7'b0000000, 7'b0000000, 1'b0};
    tbl[1]  = '{1,  1'b1, 1'b1, 16'd0, 7'b0000000, 7'b0000000, 1'b0};
    tbl[2]  = '{2,  1'b1, 1'b1, 16'd1, 7'b0000000, 7'b0000000, 1'b0};
    tbl[3]  = '{3,  1'b1, 1'b1, 16'd2, 7'b0000001, 7'b0000001, 1'b0};
    tbl[4]  = '{4,  1'b1, 1'b0, 16'd0, 7'b0000011, 7'b0000010, 1'b0};
    tbl[5]  = '{5,  1'b1, 1'b0, 16'd0, 7'b0000111, 7'b0000100, 1'b0};
    tbl[6]  = '{6,  1'b1, 1'b0, 16'd0, 7'b0001110, 7'b0001000, 1'b0};
    tbl[7]  = '{7,  1'b1, 1'b0, 16'd0, 7'b0011100, 7'b0010000, 1'b0};
    tbl[8]  = '{8,  1'b1, 1'b0, 16'd0, 7'b0111000, 7'b0100000, 1'b0};
    tbl[9]  = '{9,  1'b1, 1'b0, 16'd0, 7'b1110000, 7'b1000000, 1'b0};
    tbl[10] = '{10, 1'b1, 1'b0, 16'd0, 7'b1100000, 7'b0000000, 1'b0};
    tbl[11] = '{11, 1'b1, 1'b0, 16'd0, 7'b1000000, 7'b0000000, 1'b0};
    tbl[12] = '{12, 1'b1, 1'b0, 16'd0, 7'b0000000, 7'b0000000, 1'b1};
    tbl[13] = '{13, 1'b0, 1'b0, 16'd0, 7'b0000000, 7'b0000000, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_hold", pack_obs(), '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_release", pack_obs(), '0);
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
    check32("perf_reset", cycles, 32'd0);
`endif

    // Basic K=3 run, then compare against the hand table
    run_seq(3, -1, -1, -1, 0, 14, "basic");
    for (int i = 0; i < 14; i++) begin
      check($sformatf("tbl_c%0d", tbl[i].cyc), obs_log[tbl[i].cyc],
            {tbl[i].busy, tbl[i].done, 1'b0, tbl[i].rd,
             (tbl[i].rd ? tbl[i].addr : {K_W{1'b0}}), tbl[i].en, tbl[i].sync});
    end
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
    check32("perf_before_done", cyc_log[11], 32'd0);
    check32("perf_at_done", cyc_log[12], 32'd12);
    check32("perf_held", cycles, 32'd12);
`endif

    // Zero length: error pulse at cycle 1 only, no activity
    @(negedge clk);
    start = 1'b1; k = '0;
    @(negedge clk);
    check("zero_c1", pack_obs(), {3'b001, {(OW-3){1'b0}}});
    start = 1'b0;
    @(negedge clk);
    check("zero_c2", pack_obs(), '0);

    // Starts at cycles 5 and 12 ignored, start at 13 (K=2) accepted
    run_seq(3, 5, 12, 13, 2, 25, "busy");

    // Single product: o_done at cycle 10
    run_seq(1, -1, -1, -1, 0, 11, "k1");
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
    check32("perf_k1", cycles, 32'd10);
`endif

    // Reset mid-run at cycle 6
    @(negedge clk);
    start = 1'b1; k = K_W'(3);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("abort_c%0d", c), pack_obs(), model_run(c, 0, 3));
    end
    rst_n = 1'b0;
    #1;
    check("abort_async", pack_obs(), '0);
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
    check32("perf_abort", cycles, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("abort_quiet%0d", c), pack_obs(), '0);
    end

    // Clean run after the reset
    run_seq(2, -1, -1, -1, 0, 12, "after_rst");
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
    check32("perf_after_rst", cycles, 32'd11);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
